// File: rtl/dmem_pkg.sv
// Shared definitions for the parametrised data memory: FSM encoding and
// default geometry.
package dmem_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_DEPTH  = 128;

  localparam int unsigned STATE_W = 2;

  // Sweep-initialise, wait for access, write armed by the debug button
  localparam logic [STATE_W-1:0] ST_INIT  = 2'd0;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd1;
  localparam logic [STATE_W-1:0] ST_ARMED = 2'd2;

endpackage

// File: rtl/dmem_edge_detect.sv
// Rising-edge detector for the (already synchronised) debug write button.
module dmem_edge_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  // Previous sample of the button level
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/data_memory_param.sv
// Parametrised data memory: sweep-initialised contents, byte-enable writes,
// registered reads with range checking, and a debugger peek port. With GATED
// set, a processor write only lands after the debug button has armed it.
module data_memory_param
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned GATED  = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     writeData,
  input  logic [DATA_W/8-1:0]   byteEn,
  input  logic                  memWrite,
  input  logic                  memRead,
  input  logic                  writeEnable,
  input  logic [31:0]           peekAddr,
  output logic [DATA_W-1:0]     readData,
  output logic                  readValid,
  output logic [DATA_W-1:0]     peekData,
  output logic                  ready,
  output logic                  addrErr
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [AW-1:0]      cnt_q;
  logic [AW-1:0]      cnt_d;

  logic               we_rise_c;
  logic               in_range_c;
  logic               access_c;
  logic [AW-1:0]      addr_idx_c;
  logic [AW-1:0]      peek_idx_c;

  logic               mem_we_c;
  logic [AW-1:0]      mem_waddr_c;
  logic [DATA_W-1:0]  mem_wdata_c;
  logic [NB-1:0]      mem_wmask_c;
  logic [DATA_W-1:0]  mem_wword_c;

  dmem_edge_detect u_edge (
    .Clk    (Clk),
    .Rst    (Rst),
    .d      (writeEnable),
    .rise_c (we_rise_c)
  );

  // Address decode shared by the read, write and error paths
  always_comb begin
    in_range_c = (addr < DEPTH_W);
    access_c   = (state_q != ST_INIT);
    addr_idx_c = addr[AW-1:0];
    peek_idx_c = (peekAddr < DEPTH_W) ? peekAddr[AW-1:0] : LAST_IDX;
  end

  // State register and init counter
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and the single memory write port request
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = addr_idx_c;
    mem_wdata_c = writeData;
    mem_wmask_c = byteEn;

    case (state_q)
      ST_INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = DATA_W'(cnt_q);
        mem_wmask_c = '1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      ST_IDLE: begin
        if (GATED != 0) begin
          // A button edge arms only; a write in the same cycle is dropped
          if (we_rise_c) begin
            state_d = ST_ARMED;
          end
        end else if (memWrite && in_range_c) begin
          mem_we_c = 1'b1;
        end
      end

      ST_ARMED: begin
        // Out-of-range writes keep the arm so the user can retry
        if (memWrite && in_range_c) begin
          mem_we_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Byte-merge the write data into the current word
  always_comb begin
    mem_wword_c = mem[mem_waddr_c];
    for (int k = 0; k < NB; k++) begin
      if (mem_wmask_c[k]) begin
        mem_wword_c[8*k +: 8] = mem_wdata_c[8*k +: 8];
      end
    end
  end

  // Memory array; contents are not reset, the INIT sweep defines them
  always_ff @(posedge Clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wword_c;
    end
  end

  // Registered read, range error pulse and ready flag
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      readData  <= '0;
      readValid <= 1'b0;
      addrErr   <= 1'b0;
      ready     <= 1'b0;
    end else begin
      readValid <= access_c & memRead;
      addrErr   <= access_c & (memRead | memWrite) & ~in_range_c;
      ready     <= (state_d != ST_INIT);
      if (access_c && memRead) begin
        readData <= in_range_c ? mem[addr_idx_c] : '0;
      end
    end
  end

  // Debugger peek, saturated to the last word
  assign peekData = mem[peek_idx_c];

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: a gated (GATED=1) and an ungated (GATED=0)
// instance share stimulus; a word-array model predicts both.
module tb_data_memory_param;

  localparam int unsigned DEPTH = 128;

  logic        Clk;
  logic        Rst;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [3:0]  byteEn;
  logic        memWrite;
  logic        memRead;
  logic        writeEnable;
  logic [31:0] peekAddr;

  logic [31:0] rd_g, rd_n, pk_g, pk_n;
  logic        rdv_g, rdv_n, rdy_g, rdy_n, err_g, err_n;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_mem_g [DEPTH];
  logic [31:0] m_mem_n [DEPTH];
  bit          m_armed;
  bit          m_prev_we;
  logic [31:0] m_rd_g, m_rd_n;
  bit          m_rdv, m_err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        mw;
    logic        mr;
    logic        we;
    logic [31:0] rd;
    logic        rdv;
    logic        err;
  } vec_t;

  vec_t vec [19];

  data_memory_param #(.DATA_W(32), .DEPTH(DEPTH), .GATED(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .addr(addr), .writeData(writeData), .byteEn(byteEn),
    .memWrite(memWrite), .memRead(memRead), .writeEnable(writeEnable),
    .peekAddr(peekAddr), .readData(rd_g), .readValid(rdv_g), .peekData(pk_g),
    .ready(rdy_g), .addrErr(err_g)
  );

  data_memory_param #(.DATA_W(32), .DEPTH(DEPTH), .GATED(0)) u_dut_ng (
    .Clk(Clk), .Rst(Rst), .addr(addr), .writeData(writeData), .byteEn(byteEn),
    .memWrite(memWrite), .memRead(memRead), .writeEnable(writeEnable),
    .peekAddr(peekAddr), .readData(rd_n), .readValid(rdv_n), .peekData(pk_n),
    .ready(rdy_n), .addrErr(err_n)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                              input logic mw, input logic mr, input logic we,
                              input logic [31:0] rd, input logic rdv, input logic err);
    vec_t v;
    v.a = a; v.wd = wd; v.be = be; v.mw = mw; v.mr = mr; v.we = we;
    v.rd = rd; v.rdv = rdv; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem_g[i] = 32'(i);
      m_mem_n[i] = 32'(i);
    end
    m_armed = 0; m_prev_we = 0; m_rd_g = '0; m_rd_n = '0; m_rdv = 0; m_err = 0;
  endtask

  task automatic idle_inputs();
    addr = '0; writeData = '0; byteEn = '0; memWrite = 0; memRead = 0;
    writeEnable = 0; peekAddr = '0;
  endtask

  // One processor cycle: drive, predict, clock, compare
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic mw, input logic mr, input logic we, input logic [31:0] pk);
    bit in_r, rise;
    int pi;
    addr = a; writeData = wd; byteEn = be; memWrite = mw; memRead = mr;
    writeEnable = we; peekAddr = pk;
    in_r = (a < DEPTH);
    rise = we && !m_prev_we;
    m_prev_we = we;
    m_err = (mr || mw) && !in_r;
    m_rdv = mr;
    if (mr) begin
      m_rd_g = in_r ? m_mem_g[int'(a)] : 32'h0;
      m_rd_n = in_r ? m_mem_n[int'(a)] : 32'h0;
    end
    if (m_armed) begin
      if (mw && in_r) begin
        m_mem_g[int'(a)] = merge(m_mem_g[int'(a)], wd, be);
        m_armed = 0;
      end
    end else if (rise) begin
      m_armed = 1;
    end
    if (mw && in_r) m_mem_n[int'(a)] = merge(m_mem_n[int'(a)], wd, be);
    pi = (pk > DEPTH - 1) ? DEPTH - 1 : int'(pk);
    @(posedge Clk);
    #1;
    chk("g_ready", 32'(rdy_g), 32'd1);
    chk("n_ready", 32'(rdy_n), 32'd1);
    chk("g_readValid", 32'(rdv_g), 32'(m_rdv));
    chk("n_readValid", 32'(rdv_n), 32'(m_rdv));
    chk("g_readData", rd_g, m_rd_g);
    chk("n_readData", rd_n, m_rd_n);
    chk("g_addrErr", 32'(err_g), 32'(m_err));
    chk("n_addrErr", 32'(err_n), 32'(m_err));
    chk("g_peek", pk_g, m_mem_g[pi]);
    chk("n_peek", pk_n, m_mem_n[pi]);
  endtask

  // Hold reset, check reset values, release and time the init sweep
  task automatic reset_and_init();
    int edges;
    Rst = 0;
    idle_inputs();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_ready", 32'(rdy_g), 32'd0);
    chk("rst_readValid", 32'(rdv_g), 32'd0);
    chk("rst_readData", rd_g, 32'h0);
    chk("rst_addrErr", 32'(err_g), 32'd0);
    chk("rst_n_ready", 32'(rdy_n), 32'd0);
    Rst = 1;
    edges = 0;
    while (!rdy_g && edges < 400) begin
      @(posedge Clk);
      #1;
      edges++;
    end
    chk("init_edges", 32'(edges), 32'(DEPTH));
    chk("init_n_ready", 32'(rdy_n), 32'd1);
    model_reset();
  endtask

  task automatic sweep_peek();
    for (int i = 0; i < DEPTH + 2; i++) cyc(32'h0, 32'h0, 4'h0, 0, 0, 0, 32'(i));
  endtask

  initial begin
    Rst = 0;
    idle_inputs();
    model_reset();

    // Directed sequence on the gated instance, starting from memory[i] = i
    vec[0]  = mk(32'd5,   32'h0,        4'hF, 0, 1, 0, 32'd5,        1, 0);
    vec[1]  = mk(32'd10,  32'hDEADBEEF, 4'hF, 1, 0, 0, 32'd5,        0, 0);
    vec[2]  = mk(32'd10,  32'h0,        4'hF, 0, 1, 0, 32'd10,       1, 0);
    vec[3]  = mk(32'd0,   32'h0,        4'hF, 0, 0, 1, 32'd10,       0, 0);
    vec[4]  = mk(32'd10,  32'hDEADBEEF, 4'hF, 1, 0, 1, 32'd10,       0, 0);
    vec[5]  = mk(32'd10,  32'h0,        4'hF, 0, 1, 0, 32'hDEADBEEF, 1, 0);
    vec[6]  = mk(32'd128, 32'h0,        4'hF, 0, 1, 1, 32'h0,        1, 1);
    vec[7]  = mk(32'd200, 32'h1234,     4'hF, 1, 0, 0, 32'h0,        0, 1);
    vec[8]  = mk(32'd4,   32'hAABBCCDD, 4'h2, 1, 0, 0, 32'h0,        0, 0);
    vec[9]  = mk(32'd4,   32'h0,        4'hF, 0, 1, 0, 32'h0000CC04, 1, 0);
    vec[10] = mk(32'd0,   32'h0,        4'hF, 0, 0, 1, 32'h0000CC04, 0, 0);
    vec[11] = mk(32'd7,   32'h55,       4'hF, 1, 1, 0, 32'd7,        1, 0);
    vec[12] = mk(32'd7,   32'h0,        4'hF, 0, 1, 0, 32'h55,       1, 0);
    vec[13] = mk(32'd20,  32'hFF,       4'hF, 1, 0, 1, 32'h55,       0, 0);
    vec[14] = mk(32'd20,  32'h0,        4'hF, 0, 1, 0, 32'd20,       1, 0);
    vec[15] = mk(32'd20,  32'hFFFFFFFF, 4'h0, 1, 0, 0, 32'd20,       0, 0);
    vec[16] = mk(32'd20,  32'hFF,       4'hF, 1, 0, 0, 32'd20,       0, 0);
    vec[17] = mk(32'd20,  32'h0,        4'hF, 0, 1, 0, 32'd20,       1, 0);
    vec[18] = mk(32'd127, 32'h0,        4'hF, 0, 1, 0, 32'd127,      1, 0);

    reset_and_init();

    cyc(32'h0, 32'h0, 4'h0, 0, 0, 0, 32'd5);
    chk("peek5", pk_g, 32'd5);
    cyc(32'h0, 32'h0, 4'h0, 0, 0, 0, 32'd300);
    chk("peek300", pk_g, 32'd127);

    for (int i = 0; i < 19; i++) begin
      cyc(vec[i].a, vec[i].wd, vec[i].be, vec[i].mw, vec[i].mr, vec[i].we, vec[i].a);
      chk($sformatf("tbl%0d_readData", i), rd_g, vec[i].rd);
      chk($sformatf("tbl%0d_readValid", i), 32'(rdv_g), 32'(vec[i].rdv));
      chk($sformatf("tbl%0d_addrErr", i), 32'(err_g), 32'(vec[i].err));
    end
    chk("tbl_mem10", m_mem_g[10], 32'hDEADBEEF);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 7);
      if (r < 4)       a = 32'($urandom_range(0, 15));
      else if (r < 6)  a = 32'($urandom_range(0, 127));
      else if (r == 6) a = 32'($urandom_range(126, 129));
      else             a = 32'($urandom_range(128, 5000));
      cyc(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 300)));
    end

    // Reset in the middle of the init sweep: the sweep must restart from 0
    Rst = 0;
    idle_inputs();
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1;
    repeat (60) @(posedge Clk);
    #1;
    chk("midinit_ready", 32'(rdy_g), 32'd0);
    Rst = 0;
    #1;
    chk("midinit_rst_ready", 32'(rdy_g), 32'd0);
    reset_and_init();
    sweep_peek();

    // Reset while armed: the arm is discarded
    cyc(32'h0, 32'h0, 4'h0, 0, 0, 1, 32'd0);
    cyc(32'h0, 32'h0, 4'h0, 0, 0, 0, 32'd0);
    chk("armed_model", 32'(m_armed), 32'd1);
    reset_and_init();
    cyc(32'd30, 32'hCAFE, 4'hF, 1, 0, 0, 32'd30);
    cyc(32'd30, 32'h0, 4'hF, 0, 1, 0, 32'd30);
    chk("rst_disarm_read", rd_g, 32'd30);
    chk("ungated_write", rd_n, 32'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_param.md
# data_memory_param

Parametrised data memory for the unpipelined processor, the successor to the fixed 128-word data memory. It generalises word width and depth and adds byte-enable writes. Contents are initialised after reset by a counter sweep instead of in a single cycle. Reads are registered and out-of-range accesses are flagged. The debugger keeps its combinational peek port and its button-gated single-write mode, now selectable by parameter. The block sits between the ALU/address path and the write-back mux; the peek port goes to the board display logic.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- DEPTH, 128, number of words; any value ≥ 2
- GATED, 1, 1 = write only after a writeEnable rising edge arms the FSM; 0 = every memWrite writes
- Clk  in  1  clock; all state changes on the rising edge
- Rst  in  1  reset; asynchronous, active-low
- addr  in  32  word address for processor access
- writeData  in  DATA_W  write data
- byteEn  in  DATA_W/8  per-byte write mask; bit k covers bits 8k+7:8k
- memWrite  in  1  write request
- memRead  in  1  read request
- writeEnable  in  1  debug button level, already synchronised
- peekAddr  in  32  debugger word address
- readData  out  DATA_W  registered read data
- readValid  out  1  high the cycle readData holds a result
- peekData  out  DATA_W  combinational peek data
- ready  out  1  high once initialisation has completed
- addrErr  out  1  one-cycle pulse on an out-of-range access

## Operation
- States: INIT, IDLE, ARMED.
- INIT: an init counter runs 0..DEPTH-1 and writes memory[idx] = idx, zero-extended to DATA_W, one word per cycle. ready is low. memRead, memWrite and writeEnable are ignored.
- INIT exits to IDLE after writing idx = DEPTH-1. ready goes high the next cycle.
- IDLE, GATED=1: a writeEnable rising edge (previous sample 0, current 1) moves the FSM to ARMED. memWrite alone does not write.
- IDLE, GATED=0: memWrite performs the write directly. The ARMED state is unreachable.
- ARMED: memWrite writes the bytes of memory[addr] selected by byteEn, then the FSM returns to IDLE. Further writeEnable edges keep it in ARMED; arming does not stack.
- With byteEn = 0 a write request counts as performed (it disarms the FSM) but changes no byte.
- Out of range means addr ≥ DEPTH. Such an access pulses addrErr when memRead or memWrite is high in IDLE or ARMED. The write is suppressed and ARMED is kept. A read returns 0 with readValid = 1.
- Read: memRead sampled in IDLE or ARMED gives readData = memory[addr] and readValid = 1 on the next cycle. Otherwise readData holds its value and readValid = 0.
- peekData = memory[min(peekAddr, DEPTH-1)] combinationally. During INIT it returns the current contents.

## Timing
- Async reset values: state = INIT, counter = 0, ready = 0, readValid = 0, readData = 0, addrErr = 0, edge register = 0. The memory array is not reset.
- Init takes DEPTH cycles after Rst deasserts. ready rises on cycle DEPTH+1.
- Reset asserted mid-INIT or mid-ARMED aborts immediately and the sweep restarts from 0 on release. An armed write is discarded.
- Read latency is 1 cycle.
- Read and write to the same address in the same cycle: readData returns the old word (read-before-write). The new word is visible to peek from the next cycle.
- A writeEnable edge and memWrite in the same cycle in IDLE: the FSM arms only and no write occurs.
- addrErr is registered: it is high for exactly one cycle after the offending sample.

## Structure
- Shared package dmem_pkg: state encoding (INIT, IDLE, ARMED), DEFAULT_DATA_W, DEFAULT_DEPTH.
- Counter width is $clog2(DEPTH).
- One sub-module, dmem_edge_detect: a rising-edge detector on writeEnable with an asynchronous active-low clear.

## Test plan
- Release reset with DEPTH=128: ready rises on cycle 129. Peek 5 returns 5. Peek 300 returns 127.
- GATED=1, memWrite, addr=10, writeData=0xDEADBEEF with no arm: memory[10] stays 10. Then pulse writeEnable and repeat the write: memory[10] = 0xDEADBEEF and the FSM is back in IDLE.
- Byte enable: with memory[4] = 4, write byteEn=4'b0010, writeData=0xAABBCCDD: memory[4] = 0x0000CC04.
- Issue memRead at addr=128: addrErr pulses for 1 cycle, readData = 0, readValid = 1. With the FSM armed, a memWrite at addr=200 leaves it ARMED and memory unchanged.
- Same-cycle read and write to addr 7 with new data 0x55: readData = 7, then a read on the next cycle returns 0x55.
- Assert Rst at counter = 60 during INIT: ready stays 0 and the sweep restarts from 0. Also assert Rst while ARMED, then issue memWrite once ready is high: no write occurs.
